// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared definitions for the decoder scan sequencer: FSM state encoding and
// default widths.
package decoder_scan_sequencer_pkg;

    localparam int DEF_SEL_W   = 3;
    localparam int DEF_DWELL_W = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int NUM_CH      = 2 ** DEF_SEL_W;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/decoder_scan_sequencer_next_channel_finder.sv
// Combinational channel search: next enabled channel after the current one
// (circular), a wrap flag, and the lowest enabled channel.
module next_channel_finder
    import decoder_scan_sequencer_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [SEL_W-1:0]      i_sel,
    input  logic [2**SEL_W-1:0]   i_mask,
    output logic [SEL_W-1:0]      o_next,
    output logic                  o_wrapped,
    output logic [SEL_W-1:0]      o_lowest
);

    localparam int N_CH = 2 ** SEL_W;

    always_comb begin
        logic             w_found;
        logic [SEL_W-1:0] w_idx;
        // NOTE: every output and temporary gets a default first so no path leaves them unassigned (no latch).
        o_next  = i_sel;
        w_found = 1'b0;
        w_idx   = '0;
        // k == N_CH truncates to i_sel itself, which covers the single-channel case.
        for (int k = 1; k <= N_CH; k++) begin
            w_idx = i_sel + SEL_W'(k);
            if (!w_found && i_mask[w_idx]) begin
                o_next  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign o_wrapped = (o_next <= i_sel);

    always_comb begin
        o_lowest = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i_mask[i]) o_lowest = SEL_W'(i);
        end
    end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Scans the enabled decoder channels in ascending order, holding each for
// dwell+1 cycles, with wrap pulse and saturating full-scan counter.
module decoder_scan_sequencer
    import decoder_scan_sequencer_pkg::*;
#(
    parameter int SEL_W   = DEF_SEL_W,
    parameter int DWELL_W = DEF_DWELL_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic [2**SEL_W-1:0]  mask,
    output logic [SEL_W-1:0]     sel,
    output logic                 sel_valid,
    output logic                 busy,
    output logic                 wrap,
    output logic [CNT_W-1:0]     scan_cnt
);

    state_t               r_state;
    logic [2**SEL_W-1:0]  r_mask;
    logic [DWELL_W-1:0]   r_dwell;
    logic [DWELL_W-1:0]   r_dwell_cnt;
    logic [SEL_W-1:0]     r_sel;
    logic                 r_sel_valid;
    logic                 r_busy;
    logic                 r_wrap;
    logic [CNT_W-1:0]     r_scan_cnt;

    logic [2**SEL_W-1:0]  w_find_mask;
    logic [SEL_W-1:0]     w_next;
    logic                 w_wrapped;
    logic [SEL_W-1:0]     w_lowest;

    // In IDLE the live mask feeds the finder so the first channel is ready on the start edge.
    assign w_find_mask = (r_state == IDLE) ? mask : r_mask;

    next_channel_finder #(.SEL_W(SEL_W)) u_finder (
        .i_sel     (r_sel),
        .i_mask    (w_find_mask),
        .o_next    (w_next),
        .o_wrapped (w_wrapped),
        .o_lowest  (w_lowest)
    );

    // NOTE: all state here is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_dwell     <= '0;
            r_dwell_cnt <= '0;
            r_sel       <= '0;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_wrap      <= 1'b0;
            r_scan_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_sel       <= '0;
                    r_sel_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_wrap      <= 1'b0;
                    if (start && !stop && (mask != '0)) begin
                        r_state     <= SCAN;
                        r_mask      <= mask;
                        r_dwell     <= dwell;
                        r_dwell_cnt <= '0;
                        r_scan_cnt  <= '0;
                        r_sel       <= w_lowest;
                        r_sel_valid <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        r_state     <= IDLE;
                        r_sel       <= '0;
                        r_sel_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_wrap      <= 1'b0;
                    end else if (r_dwell_cnt == r_dwell) begin
                        r_dwell_cnt <= '0;
                        r_sel       <= w_next;
                        r_wrap      <= w_wrapped;
                        if (w_wrapped && (r_scan_cnt != '1))
                            r_scan_cnt <= r_scan_cnt + 1'b1;
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + 1'b1;
                        r_wrap      <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sel       = r_sel;
    assign sel_valid = r_sel_valid;
    assign busy      = r_busy;
    assign wrap      = r_wrap;
    assign scan_cnt  = r_scan_cnt;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Scoreboard bench: a list-based scan model predicts every cycle's outputs,
// a monitor compares them against the DUT on the falling edge.
module tb_decoder_scan_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] dwell;
    logic [7:0] mask;
    logic [2:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       wrap;
    logic [7:0] scan_cnt;

    decoder_scan_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .dwell     (dwell),
        .mask      (mask),
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy),
        .wrap      (wrap),
        .scan_cnt  (scan_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic       valid;
        logic       busy;
        logic       wrap;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, act, exp);
        end
    endtask

    // Reference model: scan is an ordered list of enabled channels with a position and hold count.
    int   chans[$];
    int   pos;
    int   held;
    int   m_dwell;
    int   m_cnt = 0;
    bit   scanning = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        cycle++;
        e = '0;
        if (rst) begin
            scanning = 1'b0;
            m_cnt    = 0;
        end else if (!scanning) begin
            if (start && !stop && mask != 8'h00) begin
                chans.delete();
                for (int i = 0; i < 8; i++) if (mask[i]) chans.push_back(i);
                pos      = 0;
                held     = 0;
                m_dwell  = int'(dwell);
                m_cnt    = 0;
                scanning = 1'b1;
                e.sel    = 3'(chans[0]);
                e.valid  = 1'b1;
                e.busy   = 1'b1;
            end
        end else if (stop) begin
            scanning = 1'b0;
        end else begin
            if (held == m_dwell) begin
                held = 0;
                pos  = (pos + 1) % chans.size();
                if (pos == 0) begin
                    e.wrap = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
            end else begin
                held++;
            end
            e.sel   = 3'(chans[pos]);
            e.valid = 1'b1;
            e.busy  = 1'b1;
        end
        e.cnt = 8'(m_cnt);
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sel",       32'(sel),       32'(e.sel));
            check("sel_valid", 32'(sel_valid), 32'(e.valid));
            check("busy",      32'(busy),      32'(e.busy));
            check("wrap",      32'(wrap),      32'(e.wrap));
            check("scan_cnt",  32'(scan_cnt),  32'(e.cnt));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic [7:0] m, input logic [7:0] d);
        mask  = m;
        dwell = d;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        dwell = 8'd0;
        mask  = 8'h00;
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // Full scan, one cycle per channel.
        do_start(8'hFF, 8'd0);
        cyc(10);
        do_stop();
        cyc(1);

        // Reset in the fifth SCAN cycle; restart needed afterwards.
        do_start(8'hFF, 8'd2);
        cyc(4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(3);

        // Sparse mask with dwell.
        do_start(8'b1010_0100, 8'd2);
        cyc(12);
        do_stop();

        // Single channel, then start with an empty mask.
        do_start(8'h08, 8'd1);
        cyc(6);
        do_stop();
        do_start(8'h00, 8'd1);
        cyc(2);

        // start and stop together in IDLE.
        mask  = 8'hFF;
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        cyc(1);

        // Stop lands on the advance cycle out of sel=7.
        do_start(8'hFF, 8'd1);
        cyc(15);
        do_stop();
        cyc(2);

        // Saturation with input churn during SCAN.
        do_start(8'h01, 8'd0);
        for (int i = 0; i < 300; i++) begin
            mask  = 8'($urandom);
            dwell = 8'($urandom);
            start = 1'($urandom_range(0, 1));
            cyc(1);
        end
        start = 1'b0;
        do_stop();
        cyc(1);

        // Random control traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       mask = 8'h00;
                1:       mask = 8'(1 << $urandom_range(0, 7));
                default: mask = 8'($urandom);
            endcase
            dwell = 8'($urandom_range(0, 3));
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            cyc(1);
        end
        start = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
